serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_word_tx.sv | 141 ++++++++++++++
 tb/tb_serial_word_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// serial_word_tx: MSB-first parallel-to-serial transmitter with last/div4 frame flags and a post-frame idle gap.
// Optional macro SERIAL_WORD_TX_PARITY_EN appends one even-parity bit after the LSB.
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             div4
);

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [GW-1:0]    gap_reg, gap_next;
  logic             div4_pend_reg, div4_pend_next;
  logic             out_reg, out_next;
  logic             valid_reg, valid_next;
  logic             last_reg, last_next;
  logic             div4_reg, div4_next;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam logic [CW-1:0] LSB_IDX = CW'(WIDTH - 1);
  logic             parity_reg, parity_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      gap_reg       <= '0;
      div4_pend_reg <= 1'b0;
      out_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      div4_reg      <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      gap_reg       <= gap_next;
      div4_pend_reg <= div4_pend_next;
      out_reg       <= out_next;
      valid_reg     <= valid_next;
      last_reg      <= last_next;
      div4_reg      <= div4_next;
`ifdef SERIAL_WORD_TX_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  // out_reg holds the bit currently on the line; cnt_reg is that bit's index in the frame.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    gap_next       = gap_reg;
    div4_pend_next = div4_pend_reg;
    out_next       = 1'b0;
    valid_next     = 1'b0;
    last_next      = 1'b0;
    div4_next      = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
    parity_next    = parity_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          shift_next     = {din[WIDTH-2:0], 1'b0};
          out_next       = din[WIDTH-1];
          valid_next     = 1'b1;
          cnt_next       = '0;
          div4_pend_next = (din[1:0] == 2'b00);
`ifdef SERIAL_WORD_TX_PARITY_EN
          parity_next    = ^din;
`endif
          state_next     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == LAST_IDX) begin
          gap_next   = '0;
          state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          valid_next = 1'b1;
          last_next  = (cnt_next == LAST_IDX);
          div4_next  = last_next & div4_pend_reg;
`ifdef SERIAL_WORD_TX_PARITY_EN
          if (cnt_reg == LSB_IDX) begin
            out_next = parity_reg;
          end else begin
            out_next   = shift_reg[WIDTH-1];
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          end
`else
          out_next   = shift_reg[WIDTH-1];
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
`endif
        end
      end
      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ready     = (state_reg == ST_IDLE);
  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign last      = last_reg;
  assign div4      = div4_reg;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: driver pushes expected frame bits tagged with their cycle, a monitor pops and compares.
// A second GAP=0 instance is checked for back-to-back framing while load is held high.
module tb_serial_word_tx;
  localparam int W = 8;
  localparam int G = 1;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif
  localparam int P2 = FRAME + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0] din = '0;
  logic load = 1'b0;
  logic ready, out, out_valid, last, div4;
  logic [W-1:0] din2 = 8'h04;
  logic load2 = 1'b0;
  logic ready2, out2, out_valid2, last2, div42;

  serial_word_tx #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .reset(reset), .din(din), .load(load), .ready(ready),
    .out(out), .out_valid(out_valid), .last(last), .div4(div4)
  );

  serial_word_tx #(.WIDTH(W), .GAP(0)) dut_g0 (
    .clk(clk), .reset(reset), .din(din2), .load(load2), .ready(ready2),
    .out(out2), .out_valid(out_valid2), .last(last2), .div4(div42)
  );

  always #5 clk = ~clk;

  int edge_num = 0;
  always @(posedge clk) edge_num <= edge_num + 1;

  typedef struct { int tag; logic b; logic l; logic d; } item_t;
  typedef struct { int tag; logic r; } rdy_t;
  item_t exp_q[$];
  rdy_t  rdy_q[$];
  int idle_from = 0;
  int checks = 0;
  int passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_num, act, expv);
  endfunction

  // Reference: bit k of a word accepted at edge e is on the line right after edge e+k.
  function automatic void push_frame(logic [W-1:0] word, int e);
    for (int k = 0; k < FRAME; k++) begin
      item_t it;
      it.tag = e + k;
      it.b   = (k < W) ? word[W-1-k] : ^word;
      it.l   = (k == FRAME - 1);
      it.d   = it.l && (word % 4 == 0);
      exp_q.push_back(it);
    end
  endfunction

  // Called just after edge m; sets inputs for edge m+1.
  task automatic drive(input logic l, input logic [W-1:0] d);
    int m;
    rdy_t r;
    m = edge_num;
    r.tag = m;
    r.r = (m + 1 >= idle_from);
    rdy_q.push_back(r);
    load = l;
    din  = d;
    if (l && (m + 1 >= idle_from)) begin
      push_frame(d, m + 1);
      idle_from = m + 1 + FRAME + G + 1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    item_t it;
    rdy_t r;
    if (!reset) begin
      chk("reset_outputs", {out_valid, out, last, div4}, 0);
      chk("reset_ready", ready, 1);
    end else begin
      while (rdy_q.size() > 0 && rdy_q[0].tag < edge_num) void'(rdy_q.pop_front());
      if (rdy_q.size() > 0 && rdy_q[0].tag == edge_num) begin
        r = rdy_q.pop_front();
        chk("ready", ready, r.r);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          it = exp_q.pop_front();
          chk("bit_cycle", edge_num, it.tag);
          chk("bit_out_last_div4", {out, last, div4}, {it.b, it.l, it.d});
        end
      end else begin
        chk("idle_zero", {out, last, div4}, 0);
        if (exp_q.size() > 0 && exp_q[0].tag <= edge_num) begin
          chk("missing_bit", out_valid, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // GAP=0 instance: period FRAME+1 starting at the first edge after reset release.
  logic ph2 = 1'b0;
  int s2 = 0;
  always @(negedge clk) begin
    int k;
    logic [3:0] e2;
    if (ph2 && reset && edge_num >= s2 && edge_num < s2 + 4 * P2) begin
      k = (edge_num - s2) % P2;
      if (k < FRAME)
        e2 = {1'b1, (k < W) ? din2[W-1-k] : ^din2, k == FRAME - 1, k == FRAME - 1};
      else
        e2 = 4'b0000;
      chk("gap0_stream", {out_valid2, out2, last2, div42}, e2);
    end
  end

  initial begin
    int guard;
    load2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    s2 = edge_num + 1;
    ph2 = 1'b1;
    repeat (4 * P2 + 1) @(posedge clk);
    #1;
    ph2 = 1'b0;
    load2 = 1'b0;

    drive(1'b1, 8'hB4);
    repeat (12) drive(1'b0, 8'h00);
    drive(1'b1, 8'h07);
    repeat (12) drive(1'b0, 8'h00);
    drive(1'b1, 8'hB4);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'hFF);
    repeat (12) drive(1'b0, 8'hFF);

    // Abort mid-frame: reset lands between edges and must clear the line at once.
    drive(1'b1, 8'hB4);
    repeat (3) drive(1'b0, 8'h00);
    #2;
    reset = 1'b0;
    exp_q.delete();
    rdy_q.delete();
    idle_from = 0;
    #1;
    chk("async_reset_clear", {out_valid, out, last, div4}, 0);
    chk("async_reset_ready", ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 8'h10);
    repeat (12) drive(1'b0, 8'h00);

    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) == 0), W'($urandom));

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      drive(1'b0, 8'h00);
      guard++;
    end
    drive(1'b0, 8'h00);
    chk("drain_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
